// File: rtl/muladd_pkg.sv
// Shared constants and FSM state type for the muladd array server.
package muladd_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int RW    = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/muladd_arr_ram.sv
// Operand array: one write port plus one registered read port.
// Reads beyond DEPTH return zero; contents survive reset, only the
// read register is cleared.
module muladd_arr_ram #(
    parameter int DEPTH = muladd_pkg::DEPTH,
    parameter int AW    = muladd_pkg::AW,
    parameter int DW    = muladd_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ce,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);
    import muladd_pkg::*;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q_d;
    logic [DW-1:0] q_q;

    // Array storage; deliberately has no reset so a reload is required.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Next read value: new word on ce, zero when out of range, else hold.
    always_comb begin
        q_d = q_q;
        if (ce) begin
            if (32'(raddr) < 32'(DEPTH)) begin
                q_d = mem[raddr[IW-1:0]];
            end else begin
                q_d = '0;
            end
        end
    end

    // Read data register giving the one-cycle BRAM latency the core expects.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/muladd_array_server.sv
// Responder/driver for the muladd HLS core: loads the a/b operand arrays
// from a valid/ready stream, serves the core's BRAM reads, runs the
// ap_ctrl_hs handshake and hands ap_return downstream.
module muladd_array_server #(
    parameter int DEPTH = muladd_pkg::DEPTH,
    parameter int AW    = muladd_pkg::AW,
    parameter int DW    = muladd_pkg::DW,
    parameter int RW    = muladd_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    output logic          ap_start,
    input  logic          ap_ready,
    input  logic          ap_done,
    input  logic          ap_idle,
    input  logic [RW-1:0] ap_return,
    input  logic [AW-1:0] a_address0,
    input  logic          a_ce0,
    output logic [DW-1:0] a_q0,
    input  logic [AW-1:0] b_address0,
    input  logic          b_ce0,
    output logic [DW-1:0] b_q0,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic          err
);
    import muladd_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [RW-1:0] res_data_q, res_data_d;
    logic          err_q, err_d;
    logic          wr_en;
    logic          a_oor, b_oor, bad_phase;

    // ap_idle is observed only; no decision depends on it.
    logic unused_ap_idle;
    assign unused_ap_idle = ap_idle;

    muladd_arr_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram_a (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_idx_q),
        .wdata (in_a),
        .ce    (a_ce0),
        .raddr (a_address0),
        .q     (a_q0)
    );

    muladd_arr_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram_b (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_idx_q),
        .wdata (in_b),
        .ce    (b_ce0),
        .raddr (b_address0),
        .q     (b_q0)
    );

    assign a_oor     = a_ce0 && (32'(a_address0) >= 32'(DEPTH));
    assign b_oor     = b_ce0 && (32'(b_address0) >= 32'(DEPTH));
    assign bad_phase = (state_q == LOAD) || (state_q == OUT);

    // Next-state, load indexing, result capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        res_data_d = res_data_q;
        wr_en      = 1'b0;
        in_ready   = (state_q == LOAD);
        ap_start   = (state_q == START);
        res_valid  = (state_q == OUT);

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = START;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            START: begin
                if (ap_ready) begin
                    if (ap_done) begin
                        res_data_d = ap_return;
                        state_d    = OUT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ap_done) begin
                    res_data_d = ap_return;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Sticky protocol-error flag: bad addresses, reads or done outside a run.
    always_comb begin
        err_d = err_q;
        if (a_oor || b_oor) begin
            err_d = 1'b1;
        end
        if (bad_phase && (a_ce0 || b_ce0 || ap_done)) begin
            err_d = 1'b1;
        end
    end

    // State, write index, captured result and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            wr_idx_q   <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            res_data_q <= res_data_d;
            err_q      <= err_d;
        end
    end

    assign res_data = res_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_muladd_array_server.sv
// Directed bench for muladd_array_server: a behavioural core drives the
// read ports and handshake; address width is widened to reach past DEPTH.
module tb_muladd_array_server;

    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int RW    = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [RW-1:0] ap_return;
    logic [AW-1:0] a_address0;
    logic          a_ce0;
    logic [DW-1:0] a_q0;
    logic [AW-1:0] b_address0;
    logic          b_ce0;
    logic [DW-1:0] b_q0;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] acc;

    muladd_array_server #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_return  (ap_return),
        .a_address0 (a_address0),
        .a_ce0      (a_ce0),
        .a_q0       (a_q0),
        .b_address0 (b_address0),
        .b_ce0      (b_ce0),
        .b_q0       (b_q0),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b);
        in_valid = valid;
        in_a     = a;
        in_b     = b;
    endtask

    // Streams DEPTH pairs a[i]=i+a_off, b[i]=b_val and checks the start timing.
    task automatic loadArrays(input logic [DW-1:0] a_off, input logic [DW-1:0] b_val);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, DW'(i) + a_off, b_val);
            if (i == DEPTH - 1) begin
                checkOutput("no_start_before_last_beat", 64'(ap_start), 64'd0);
            end
            @(negedge clk);
        end
        applyStimulus(1'b0, '0, '0);
        checkOutput("start_after_last_beat", 64'(ap_start), 64'd1);
        checkOutput("in_ready_low_in_start", 64'(in_ready), 64'd0);
    endtask

    // Pulses ap_ready for one cycle, moving the server from START to RUN.
    task automatic pulseReady();
        ap_ready = 1'b1;
        @(negedge clk);
        ap_ready = 1'b0;
        checkOutput("start_low_after_ready", 64'(ap_start), 64'd0);
    endtask

    // Behavioural core: pipelined reads of both arrays, returns sum(a*b).
    task automatic runCore(output logic [31:0] sum);
        sum        = '0;
        a_ce0      = 1'b1;
        b_ce0      = 1'b1;
        a_address0 = '0;
        b_address0 = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            sum = sum + 32'(a_q0) * 32'(b_q0);
            if (i < DEPTH) begin
                a_address0 = AW'(i);
                b_address0 = AW'(i);
            end else begin
                a_ce0 = 1'b0;
                b_ce0 = 1'b0;
            end
        end
    endtask

    // Pulses res_ready and checks the return to LOAD.
    task automatic drainResult();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("in_ready_after_drain", 64'(in_ready), 64'd1);
        checkOutput("res_valid_after_drain", 64'(res_valid), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        ap_idle    = 1'b1;
        ap_return  = '0;
        a_address0 = '0;
        a_ce0      = 1'b0;
        b_address0 = '0;
        b_ce0      = 1'b0;
        res_ready  = 1'b0;
        $display("[TB] starting muladd_array_server bench");

        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_ap_start", 64'(ap_start), 64'd0);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_res_data", 64'(res_data), 64'd0);
        checkOutput("reset_a_q0", 64'(a_q0), 64'd0);
        checkOutput("reset_b_q0", 64'(b_q0), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Basic run: a[i]=i+1, b[i]=2.
        loadArrays(16'd1, 16'd2);
        @(negedge clk);
        checkOutput("start_held_without_ready", 64'(ap_start), 64'd1);
        ap_idle = 1'b0;
        pulseReady();
        runCore(acc);
        checkOutput("basic_core_sum", 64'(acc), 64'd272);

        // Read latency and hold.
        a_ce0      = 1'b1;
        a_address0 = 5'd5;
        checkOutput("a_q0_not_yet_updated", 64'(a_q0), 64'd16);
        @(negedge clk);
        checkOutput("a_q0_one_cycle", 64'(a_q0), 64'd6);
        a_ce0      = 1'b0;
        b_ce0      = 1'b1;
        b_address0 = 5'd15;
        @(negedge clk);
        b_ce0 = 1'b0;
        checkOutput("b_q0_one_cycle", 64'(b_q0), 64'd2);
        checkOutput("a_q0_held", 64'(a_q0), 64'd6);
        checkOutput("err_clean_in_run", 64'(err), 64'd0);

        // Out-of-range read during RUN.
        a_ce0      = 1'b1;
        a_address0 = 5'd20;
        @(negedge clk);
        a_ce0 = 1'b0;
        checkOutput("oor_q0_zero", 64'(a_q0), 64'd0);
        checkOutput("oor_sets_err", 64'(err), 64'd1);

        // Completion.
        ap_done   = 1'b1;
        ap_return = acc;
        @(negedge clk);
        ap_done   = 1'b0;
        ap_return = '0;
        ap_idle   = 1'b1;
        checkOutput("basic_res_valid", 64'(res_valid), 64'd1);
        checkOutput("basic_res_data", 64'(res_data), 64'd272);

        // Backpressure with in_valid toggling.
        for (int c = 0; c < 5; c++) begin
            applyStimulus(c[0] == 1'b0, 16'hFFFF, 16'hFFFF);
            @(negedge clk);
            checkOutput("bp_res_valid", 64'(res_valid), 64'd1);
            checkOutput("bp_res_data", 64'(res_data), 64'd272);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        applyStimulus(1'b0, '0, '0);
        drainResult();
        a_ce0      = 1'b1;
        a_address0 = 5'd0;
        @(negedge clk);
        a_ce0 = 1'b0;
        checkOutput("no_write_during_out", 64'(a_q0), 64'd1);
        checkOutput("err_sticky", 64'(err), 64'd1);

        // Handshake corner: ready and done together.
        loadArrays(16'd1, 16'd2);
        ap_ready  = 1'b1;
        ap_done   = 1'b1;
        ap_return = 32'hDEADBEEF;
        @(negedge clk);
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        ap_return = '0;
        checkOutput("corner_start_low", 64'(ap_start), 64'd0);
        checkOutput("corner_res_valid", 64'(res_valid), 64'd1);
        checkOutput("corner_res_data", 64'(res_data), 64'hDEADBEEF);
        drainResult();

        // Reset while running.
        loadArrays(16'd3, 16'd5);
        pulseReady();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ap_start", 64'(ap_start), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_err_cleared", 64'(err), 64'd0);
        checkOutput("rst_res_data", 64'(res_data), 64'd0);

        // Read during LOAD is served but flagged.
        b_ce0      = 1'b1;
        b_address0 = 5'd3;
        @(negedge clk);
        b_ce0 = 1'b0;
        checkOutput("load_read_served", 64'(b_q0), 64'd5);
        checkOutput("load_read_err", 64'(err), 64'd1);

        // Full run after reset: a[i]=i, b[i]=3 -> 360.
        loadArrays(16'd0, 16'd3);
        pulseReady();
        runCore(acc);
        checkOutput("final_core_sum", 64'(acc), 64'd360);
        ap_done   = 1'b1;
        ap_return = acc;
        @(negedge clk);
        ap_done   = 1'b0;
        ap_return = '0;
        checkOutput("final_res_valid", 64'(res_valid), 64'd1);
        checkOutput("final_res_data", 64'(res_data), 64'd360);
        drainResult();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
